// File: rtl/jogador_automatico_if.sv
// Player <-> memory-game signal bundle; master = automatic player, slave = game side.
// Status/debug outputs travel with the handshake so the board top wires a single bundle.
interface jogador_automatico_if;
    logic       ligar;
    logic [3:0] leds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       iniciar;
    logic [3:0] botoes;
    logic       ativo;
    logic [3:0] db_rodada;
    logic [3:0] db_estado;

    modport master (
        input  ligar, leds, pronto, ganhou, perdeu,
        output iniciar, botoes, ativo, db_rodada, db_estado
    );

    modport slave (
        output ligar, leds, pronto, ganhou, perdeu,
        input  iniciar, botoes, ativo, db_rodada, db_estado
    );
endinterface

// File: rtl/jogador_automatico.sv
// Automatic memory-game player: captures the first play, replays and extends the sequence each round; outputs registered, pronto aborts next clock.
// Optional stall injection to provoke a game timeout is built only with `define TIMEOUT_INJ_EN.
module jogador_automatico #(
    parameter int NUM_RODADAS  = 16,
    parameter int START_CYCLES = 10,
    parameter int PRESS_CYCLES = 10,
    parameter int GAP_CYCLES   = 10,
    parameter int STEP         = 2,
    parameter int STALL_RODADA = 2,
    parameter int STALL_JOGADA = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    jogador_automatico_if.master bus
);
    localparam int PW = $clog2(NUM_RODADAS) + 1;
    localparam int AW = (NUM_RODADAS > 1) ? $clog2(NUM_RODADAS) : 1;

    localparam logic [15:0]   START_LD = 16'(START_CYCLES - 1);
    localparam logic [15:0]   PRESS_LD = 16'(PRESS_CYCLES - 1);
    localparam logic [15:0]   GAP_LD   = 16'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] NUM_R    = PW'(NUM_RODADAS);
    localparam logic [1:0]    STEP2    = 2'(STEP % 4);

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        PARTIDA    = 4'd1,
        ESPERA_LED = 4'd2,
        CAPTURA    = 4'd3,
        PAUSA      = 4'd4,
        PRESSIONA  = 4'd5,
        NOVA       = 4'd6,
        ESPERA_FIM = 4'd7,
        FIM        = 4'd8
    } estado_t;

    estado_t       estado_q;
    logic [15:0]   cnt_q;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] rodada_q;
    logic [1:0]    idx_q;
    logic [3:0]    botoes_q;
    logic          iniciar_q;
    logic          ativo_q;
    logic          ligar_q;
    logic [3:0]    mem_q [NUM_RODADAS];

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    logic          ligar_edge;
    logic          pronto_abort;
    logic [1:0]    idx_nova;
    logic [3:0]    onehot_nova;
    logic [3:0]    mem_rd;
    logic          stall;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [3:0]    mem_wd;
    logic [PW-1:0] rodada_m1;
    logic          unused_status;

    assign ligar_edge   = bus.ligar & ~ligar_q;
    assign pronto_abort = bus.pronto && (estado_q != INICIAL) && (estado_q != FIM);
    assign idx_nova     = idx_q + STEP2;
    assign onehot_nova  = 4'b0001 << idx_nova;
    assign mem_rd       = mem_q[pos_q[AW-1:0]];
    assign rodada_m1    = rodada_q - PW'(1);
    assign unused_status = bus.ganhou ^ bus.perdeu;

`ifdef TIMEOUT_INJ_EN
    // NOVA is reached with pos==rodada, so the same compare covers a stall on the appended play.
    assign stall = (rodada_q == PW'(STALL_RODADA)) && (pos_q == PW'(STALL_JOGADA));
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = (STALL_RODADA == STALL_JOGADA);
    assign stall = 1'b0;
`endif

    // Sequence memory writes: first play at capture, appended play when leaving PAUSA for NOVA.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = bus.leds;
        if (!pronto_abort) begin
            if (estado_q == ESPERA_LED && bus.leds != 4'b0000) begin
                mem_we = 1'b1;
            end else if (estado_q == PAUSA && cnt_q == 16'd0 && !stall &&
                         pos_q == rodada_q && rodada_q < NUM_R) begin
                mem_we = 1'b1;
                mem_wa = rodada_q[AW-1:0];
                mem_wd = onehot_nova;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= INICIAL;
            cnt_q     <= '0;
            pos_q     <= '0;
            rodada_q  <= PW'(1);
            idx_q     <= '0;
            botoes_q  <= '0;
            iniciar_q <= 1'b0;
            ativo_q   <= 1'b0;
            ligar_q   <= 1'b0;
        end else begin
            ligar_q <= bus.ligar;
            if (pronto_abort) begin
                estado_q  <= FIM;
                cnt_q     <= '0;
                botoes_q  <= '0;
                iniciar_q <= 1'b0;
                ativo_q   <= 1'b0;
            end else begin
                case (estado_q)
                    INICIAL: begin
                        if (ligar_edge) begin
                            estado_q  <= PARTIDA;
                            cnt_q     <= START_LD;
                            iniciar_q <= 1'b1;
                            ativo_q   <= 1'b1;
                            rodada_q  <= PW'(1);
                            pos_q     <= '0;
                        end
                    end
                    PARTIDA: begin
                        if (cnt_q == 16'd0) begin
                            estado_q  <= ESPERA_LED;
                            iniciar_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ESPERA_LED: begin
                        if (bus.leds != 4'b0000) begin
                            estado_q <= CAPTURA;
                            cnt_q    <= '0;
                            idx_q    <= low_idx(bus.leds);
                        end
                    end
                    CAPTURA: begin
                        if (bus.leds == 4'b0000) begin
                            estado_q <= PAUSA;
                            cnt_q    <= GAP_LD;
                        end
                    end
                    PAUSA: begin
                        if (cnt_q != 16'd0) begin
                            cnt_q <= cnt_q - 16'd1;
                        end else if (stall) begin
                            estado_q <= ESPERA_FIM;
                            cnt_q    <= '0;
                        end else if (pos_q < rodada_q) begin
                            estado_q <= PRESSIONA;
                            cnt_q    <= PRESS_LD;
                            botoes_q <= mem_rd;
                        end else if (rodada_q < NUM_R) begin
                            estado_q <= NOVA;
                            cnt_q    <= PRESS_LD;
                            idx_q    <= idx_nova;
                            botoes_q <= onehot_nova;
                        end else begin
                            estado_q <= ESPERA_FIM;
                            cnt_q    <= '0;
                        end
                    end
                    PRESSIONA: begin
                        if (cnt_q == 16'd0) begin
                            estado_q <= PAUSA;
                            cnt_q    <= GAP_LD;
                            botoes_q <= '0;
                            pos_q    <= pos_q + PW'(1);
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    NOVA: begin
                        if (cnt_q == 16'd0) begin
                            estado_q <= PAUSA;
                            cnt_q    <= GAP_LD;
                            botoes_q <= '0;
                            rodada_q <= rodada_q + PW'(1);
                            pos_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ESPERA_FIM: begin
                        botoes_q <= '0;
                    end
                    FIM: begin
                        botoes_q <= '0;
                        ativo_q  <= 1'b0;
                        if (!bus.ligar) begin
                            estado_q <= INICIAL;
                            cnt_q    <= '0;
                        end
                    end
                    default: begin
                        estado_q <= INICIAL;
                        cnt_q    <= '0;
                        botoes_q <= '0;
                        ativo_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.iniciar   = iniciar_q;
    assign bus.botoes    = botoes_q;
    assign bus.ativo     = ativo_q;
    assign bus.db_rodada = 4'(rodada_m1);
    assign bus.db_estado = estado_q;
endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico with a 4-round game played by hand-written stimulus.
// Build with +define+TIMEOUT_INJ_EN to exercise the stall path instead of the win/abort games.
module tb_jogador_automatico;
    localparam int NR  = 4;
    localparam int LIM = 3000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    jogador_automatico_if bus();

    jogador_automatico #(
        .NUM_RODADAS (NR),
        .START_CYCLES(10),
        .PRESS_CYCLES(10),
        .GAP_CYCLES  (10),
        .STEP        (2),
        .STALL_RODADA(2),
        .STALL_JOGADA(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero samples before the next press, then how long that press value is held.
    task automatic wait_press(output logic [3:0] val, output int gap, output int width);
        gap = 0;
        while (bus.botoes === 4'b0000 && gap < LIM) begin
            tick();
            gap++;
        end
        val   = bus.botoes;
        width = 0;
        while (bus.botoes === val && width < LIM) begin
            tick();
            width++;
        end
    endtask

    task automatic start_game(input logic [3:0] first);
        int n;
        bus.ligar = 1'b0;
        tick();
        tick();
        bus.ligar = 1'b1;
        n = 0;
        while (bus.db_estado !== 4'd2 && n < LIM) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= LIM) begin
            n_err++;
            $display("FAIL start_wait: ESPERA_LED not reached within %0d clocks", LIM);
        end
        bus.leds = first;
        tick();
        tick();
        tick();
        bus.leds = 4'b0000;
        tick();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.ligar  = 1'b0;
        bus.leds   = 4'b0000;
        bus.pronto = 1'b0;
        bus.ganhou = 1'b0;
        bus.perdeu = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.botoes !== 4'b0000) begin n_err++; $display("FAIL rst_botoes: got %b want 0000", bus.botoes); end
        n_cmp++; if (bus.iniciar !== 1'b0) begin n_err++; $display("FAIL rst_iniciar: got %b want 0", bus.iniciar); end
        n_cmp++; if (bus.ativo !== 1'b0) begin n_err++; $display("FAIL rst_ativo: got %b want 0", bus.ativo); end
        n_cmp++; if (bus.db_estado !== 4'd0) begin n_err++; $display("FAIL rst_estado: got %0d want 0", bus.db_estado); end
        n_cmp++; if (bus.db_rodada !== 4'd0) begin n_err++; $display("FAIL rst_rodada: got %0d want 0", bus.db_rodada); end
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.db_estado !== 4'd0) begin n_err++; $display("FAIL idle_estado: got %0d want 0", bus.db_estado); end
    endtask

    task automatic test_start_capture();
        int n;
        int w;
        int g;
        logic [3:0] v;
        bus.ligar = 1'b1;
        n = 0;
        while (bus.iniciar !== 1'b1 && n < LIM) begin
            tick();
            n++;
        end
        n_cmp++; if (n != 1) begin n_err++; $display("FAIL iniciar_delay: got %0d want 1", n); end
        w = 0;
        while (bus.iniciar === 1'b1 && w < LIM) begin
            tick();
            w++;
        end
        n_cmp++; if (w != 10) begin n_err++; $display("FAIL iniciar_width: got %0d want 10", w); end
        n_cmp++; if (bus.db_estado !== 4'd2) begin n_err++; $display("FAIL espera_led: got %0d want 2", bus.db_estado); end
        n_cmp++; if (bus.ativo !== 1'b1) begin n_err++; $display("FAIL ativo_busy: got %b want 1", bus.ativo); end
        bus.leds = 4'b0001;
        repeat (2000) tick();
        n_cmp++; if (bus.db_estado !== 4'd3) begin n_err++; $display("FAIL captura: got %0d want 3", bus.db_estado); end
        n_cmp++; if (bus.botoes !== 4'b0000) begin n_err++; $display("FAIL captura_botoes: got %b want 0000", bus.botoes); end
        bus.leds = 4'b0000;
        tick();
        wait_press(v, g, w);
        n_cmp++; if (v !== 4'b0001) begin n_err++; $display("FAIL first_press: got %b want 0001", v); end
        n_cmp++; if (g != 10) begin n_err++; $display("FAIL first_gap: got %0d want 10", g); end
        n_cmp++; if (w != 10) begin n_err++; $display("FAIL first_width: got %0d want 10", w); end
    endtask

    task automatic test_append();
        int g;
        int w;
        logic [3:0] v;
        logic [3:0] exp2 [3] = '{4'b0001, 4'b0100, 4'b0001};
        wait_press(v, g, w);
        n_cmp++; if (v !== 4'b0100) begin n_err++; $display("FAIL r1_nova: got %b want 0100", v); end
        n_cmp++; if (g != 10 || w != 10) begin n_err++; $display("FAIL r1_nova_timing: gap %0d width %0d want 10/10", g, w); end
        n_cmp++; if (bus.db_rodada !== 4'd1) begin n_err++; $display("FAIL r1_rodada: got %0d want 1", bus.db_rodada); end
`ifndef TIMEOUT_INJ_EN
        for (int i = 0; i < 3; i++) begin
            wait_press(v, g, w);
            n_cmp++;
            if (v !== exp2[i] || g != 10 || w != 10) begin
                n_err++;
                $display("FAIL r2_press%0d: got %b gap %0d width %0d want %b gap 10 width 10", i, v, g, w, exp2[i]);
            end
        end
        n_cmp++; if (bus.db_rodada !== 4'd2) begin n_err++; $display("FAIL r2_rodada: got %0d want 2", bus.db_rodada); end
`endif
    endtask

`ifdef TIMEOUT_INJ_EN
    task automatic test_timeout();
        int g;
        int w;
        int nz;
        logic [3:0] v;
        wait_press(v, g, w);
        n_cmp++; if (v !== 4'b0001 || g != 10 || w != 10) begin n_err++; $display("FAIL stall_first: got %b gap %0d width %0d want 0001 10 10", v, g, w); end
        nz = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.botoes !== 4'b0000) nz++;
            tick();
        end
        n_cmp++; if (nz != 0) begin n_err++; $display("FAIL stall_quiet: %0d nonzero samples want 0", nz); end
        n_cmp++; if (bus.db_estado !== 4'd7) begin n_err++; $display("FAIL stall_estado: got %0d want 7", bus.db_estado); end
        n_cmp++; if (bus.db_rodada !== 4'd1) begin n_err++; $display("FAIL stall_rodada: got %0d want 1", bus.db_rodada); end
        bus.pronto = 1'b1;
        bus.perdeu = 1'b1;
        tick();
        n_cmp++; if (bus.db_estado !== 4'd8 || bus.ativo !== 1'b0) begin n_err++; $display("FAIL lose_fim: estado %0d ativo %b want 8/0", bus.db_estado, bus.ativo); end
        bus.pronto = 1'b0;
        bus.perdeu = 1'b0;
        bus.ligar  = 1'b0;
        tick();
        n_cmp++; if (bus.db_estado !== 4'd0) begin n_err++; $display("FAIL lose_inicial: got %0d want 0", bus.db_estado); end
    endtask
`else
    task automatic test_win();
        int g;
        int w;
        logic [3:0] v;
        logic [3:0] exp34 [8] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100,
                                  4'b0001, 4'b0100, 4'b0001, 4'b0100};
        for (int i = 0; i < 8; i++) begin
            wait_press(v, g, w);
            n_cmp++;
            if (v !== exp34[i] || g != 10 || w != 10) begin
                n_err++;
                $display("FAIL r34_press%0d: got %b gap %0d width %0d want %b gap 10 width 10", i, v, g, w, exp34[i]);
            end
        end
        repeat (12) tick();
        n_cmp++; if (bus.db_estado !== 4'd7) begin n_err++; $display("FAIL win_espera: got %0d want 7", bus.db_estado); end
        n_cmp++; if (bus.botoes !== 4'b0000 || bus.ativo !== 1'b1) begin n_err++; $display("FAIL win_idle: botoes %b ativo %b want 0000/1", bus.botoes, bus.ativo); end
        n_cmp++; if (bus.db_rodada !== 4'd3) begin n_err++; $display("FAIL win_rodada: got %0d want 3", bus.db_rodada); end
        bus.ligar = 1'b0;
        tick();
        bus.ligar = 1'b1;
        tick();
        n_cmp++; if (bus.db_estado !== 4'd7) begin n_err++; $display("FAIL busy_ligar: got %0d want 7", bus.db_estado); end
        bus.pronto = 1'b1;
        bus.ganhou = 1'b1;
        tick();
        n_cmp++; if (bus.db_estado !== 4'd8 || bus.ativo !== 1'b0) begin n_err++; $display("FAIL win_fim: estado %0d ativo %b want 8/0", bus.db_estado, bus.ativo); end
        bus.pronto = 1'b0;
        bus.ganhou = 1'b0;
        repeat (5) tick();
        n_cmp++; if (bus.db_estado !== 4'd8) begin n_err++; $display("FAIL fim_hold: got %0d want 8", bus.db_estado); end
        bus.ligar = 1'b0;
        tick();
        n_cmp++; if (bus.db_estado !== 4'd0) begin n_err++; $display("FAIL fim_release: got %0d want 0", bus.db_estado); end
    endtask

    task automatic test_abort();
        int g;
        int w;
        int n;
        logic [3:0] v;
        logic [3:0] exp12 [5] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
        start_game(4'b0001);
        for (int i = 0; i < 5; i++) begin
            wait_press(v, g, w);
            n_cmp++;
            if (v !== exp12[i]) begin n_err++; $display("FAIL ab_press%0d: got %b want %b", i, v, exp12[i]); end
        end
        n = 0;
        while (bus.botoes === 4'b0000 && n < LIM) begin
            tick();
            n++;
        end
        tick();
        tick();
        tick();
        n_cmp++; if (bus.botoes !== 4'b0001 || bus.db_estado !== 4'd5) begin n_err++; $display("FAIL ab_mid: botoes %b estado %0d want 0001/5", bus.botoes, bus.db_estado); end
        n_cmp++; if (bus.db_rodada !== 4'd2) begin n_err++; $display("FAIL ab_rodada: got %0d want 2", bus.db_rodada); end
        bus.pronto = 1'b1;
        tick();
        n_cmp++; if (bus.botoes !== 4'b0000) begin n_err++; $display("FAIL ab_botoes: got %b want 0000", bus.botoes); end
        n_cmp++; if (bus.db_estado !== 4'd8 || bus.ativo !== 1'b0) begin n_err++; $display("FAIL ab_fim: estado %0d ativo %b want 8/0", bus.db_estado, bus.ativo); end
        bus.pronto = 1'b0;
        repeat (10) tick();
        n_cmp++; if (bus.db_estado !== 4'd8) begin n_err++; $display("FAIL ab_hold: got %0d want 8", bus.db_estado); end
        bus.ligar = 1'b0;
        tick();
        n_cmp++; if (bus.db_estado !== 4'd0) begin n_err++; $display("FAIL ab_release: got %0d want 0", bus.db_estado); end
    endtask
`endif

    task automatic test_reset_mid_press();
        int g;
        int w;
        int n;
        logic [3:0] v;
        start_game(4'b1010);
        wait_press(v, g, w);
        n_cmp++; if (v !== 4'b1010 || g != 10) begin n_err++; $display("FAIL multi_first: got %b gap %0d want 1010 gap 10", v, g); end
        wait_press(v, g, w);
        n_cmp++; if (v !== 4'b1000) begin n_err++; $display("FAIL multi_nova: got %b want 1000", v); end
        n = 0;
        while (bus.botoes === 4'b0000 && n < LIM) begin
            tick();
            n++;
        end
        tick();
        tick();
        tick();
        tick();
        n_cmp++; if (bus.botoes !== 4'b1010 || bus.db_estado !== 4'd5) begin n_err++; $display("FAIL multi_replay: botoes %b estado %0d want 1010/5", bus.botoes, bus.db_estado); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.botoes !== 4'b0000) begin n_err++; $display("FAIL mid_rst_botoes: got %b want 0000", bus.botoes); end
        n_cmp++; if (bus.iniciar !== 1'b0 || bus.ativo !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctl: iniciar %b ativo %b want 0/0", bus.iniciar, bus.ativo); end
        n_cmp++; if (bus.db_estado !== 4'd0) begin n_err++; $display("FAIL mid_rst_estado: got %0d want 0", bus.db_estado); end
        n_cmp++; if (bus.db_rodada !== 4'd0) begin n_err++; $display("FAIL mid_rst_rodada: got %0d want 0", bus.db_rodada); end
        bus.ligar = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.db_estado !== 4'd0 || bus.botoes !== 4'b0000) begin n_err++; $display("FAIL post_rst: estado %0d botoes %b want 0/0000", bus.db_estado, bus.botoes); end
    endtask

    initial begin
        test_reset();
        test_start_capture();
        test_append();
`ifdef TIMEOUT_INJ_EN
        test_timeout();
`else
        test_win();
        test_abort();
`endif
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
